accum_mc: RTL and testbench
===========================

# accum_mc

Multi-channel, parametrised accumulator: the next generation of the single-channel step counter. It holds CHANNELS independent count registers and adds a per-transaction step to the addressed channel. Each transaction selects wrap-at-modulus or saturate-at-modulus behaviour. Results leave through a registered valid/ready output stage. It sits between step/phase generators and downstream consumers such as NCO address logic, rate dividers and event counters.

## Interface
- CHANNELS, 4, number of independent accumulators, ≥1
- CH_BIT, $clog2(CHANNELS) (min 1), channel index width
- STEP_BIT, 5, width of step input k, unsigned
- CNT_BIT, 12, accumulator width, STEP_BIT ≤ CNT_BIT
- INIT_CNT, 1, reset/clear value of every channel, < 2^CNT_BIT
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  transaction request
- in_ready  out  1  block can accept
- in_ch  in  CH_BIT  target channel
- in_op  in  1  accum_pkg::op_t: OP_ADD=0, OP_CLEAR=1
- in_k  in  STEP_BIT  step, zero-extended
- in_sat  in  1  0 = wrap mode, 1 = saturate mode
- modulus  in  CNT_BIT  quasi-static limit M; 0 means 2^CNT_BIT
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_ch  out  CH_BIT  channel of result
- out_cnt  out  CNT_BIT  post-update value of that channel
- out_flag  out  1  wrap occurred (wrap mode) or clipped (saturate mode)

## Operation
- Accept occurs when in_valid && in_ready; the addressed channel register and the output register update on that edge.
- in_ch ≥ CHANNELS: transaction is accepted; no channel changes; out_cnt=0, out_flag=0.
- OP_ADD: sum = cnt + k, computed CNT_BIT+1 wide. Let Meff = M, or 2^CNT_BIT when M=0.
  - sum < Meff: cnt ← sum, flag=0.
  - Wrap mode, sum ≥ Meff: cnt ← sum − Meff, flag=1. A single subtraction only; k < Meff is a usage requirement.
  - Saturate mode, sum ≥ Meff: cnt ← Meff − 1, flag=1. Flag is also 1 when cnt already equals Meff−1 and k>0.
  - k=0: cnt unchanged, flag=0, unless cnt ≥ Meff. In that case the wrap/saturate rule applies (e.g. M lowered below cnt).
- OP_CLEAR: cnt ← INIT_CNT, flag=0; in_k and in_sat are ignored.
- Each accept produces exactly one output beat carrying the new value.
- No read-after-write hazard: back-to-back transactions to the same channel see the previous update.
- Channels not addressed hold their value.

## Timing
- Reset (rst_n low, asynchronous assert, synchronous-safe release): all channels = INIT_CNT; out_valid=0, out_ch=0, out_cnt=0, out_flag=0; in_ready=1.
- in_ready = !out_valid || out_ready (combinational, single-entry output register).
- Latency: accept on edge N → out_valid=1 with result after edge N.
- Throughput: 1 transaction/cycle while out_ready=1.
- While out_valid && !out_ready, out_* hold stable and in_ready=0.
- Simultaneous output drain and new accept in the same cycle: out_* take the new result and out_valid stays 1.
- Reset asserted mid-operation: pending output is discarded and all channels return to INIT_CNT immediately.
- modulus must be stable for any cycle in which in_valid=1; changes take effect at the next accept.

## Structure
- Package accum_pkg: op_t enum (OP_ADD, OP_CLEAR), function for Meff, result struct {ch, cnt, flag}.
- Sub-module accum_alu: combinational next-value/flag from (cnt, k, op, sat, modulus), parametrised by STEP_BIT and CNT_BIT.
- Top level: channel register array, output register, handshake.

## Test plan
- Reset release, CHANNELS=4, CNT_BIT=12, INIT_CNT=1: OP_ADD k=0 on each channel → out_cnt=1, flag=0 for all channels.
- Wrap, M=20: ch0 starts at 1, ADD k=19 → 0, flag=1. Then ADD k=5 → 5, flag=0. ch1 is unaffected (still 1).
- Saturate, M=20: ch2 starts at 1, ADD k=18 → 19, flag=0. Then ADD k=3 → 19, flag=1. Then OP_CLEAR → 1, flag=0.
- M=0, wrap mode: ch3 driven to 4094, ADD k=3 → 1, flag=1 (natural 4096 wrap).
- Backpressure: out_ready=0 for 3 cycles during a burst to ch0 → in_ready=0, out_* held stable. On release, results arrive in order, none lost or duplicated, and final ch0 = INIT_CNT + Σk mod M.
- Async reset pulse mid-burst with out_valid=1 → outputs clear within the same cycle without waiting for a clock edge, and the next ADD k=2 on ch0 yields 3.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and helpers for the multi-channel accumulator.
package accum_pkg;

  typedef enum logic {
    OP_ADD   = 1'b0,
    OP_CLEAR = 1'b1
  } op_t;

  // Effective modulus: a zero limit stands for the full 2^width range.
  function automatic logic [32:0] meff(input logic [31:0] m, input int unsigned width);
    meff = (m == '0) ? (33'd1 << width) : {1'b0, m};
  endfunction

endpackage

// File: rtl/accum_alu.sv
// Combinational next-value and flag for one accumulator channel.
module accum_alu
  import accum_pkg::*;
#(
  parameter int unsigned STEP_BIT = 5,
  parameter int unsigned CNT_BIT  = 12,
  parameter int unsigned INIT_CNT = 1
) (
  input  logic [CNT_BIT-1:0]  i_cnt,
  input  logic [STEP_BIT-1:0] i_k,
  input  op_t                 i_op,
  input  logic                i_sat,
  input  logic [CNT_BIT-1:0]  i_modulus,
  output logic [CNT_BIT-1:0]  o_cnt,
  output logic                o_flag
);

  localparam int unsigned W = CNT_BIT + 1;

  logic [W-1:0] w_sum;
  logic [W-1:0] w_meff;

  assign w_sum  = {1'b0, i_cnt} + W'(i_k);
  assign w_meff = W'(meff(32'(i_modulus), CNT_BIT));

  always_comb begin
    o_cnt  = i_cnt;
    o_flag = 1'b0;
    if (i_op == OP_CLEAR) begin
      o_cnt = CNT_BIT'(INIT_CNT);
    end else if (w_sum >= w_meff) begin
      // Also catches k=0 when the limit was lowered below the stored count.
      o_flag = 1'b1;
      o_cnt  = i_sat ? CNT_BIT'(w_meff - W'(1)) : CNT_BIT'(w_sum - w_meff);
    end else begin
      o_cnt = CNT_BIT'(w_sum);
    end
  end

endmodule

// File: rtl/accum_mc.sv
// Multi-channel wrap/saturate accumulator with a registered valid/ready output stage.
module accum_mc
  import accum_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_BIT   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int unsigned STEP_BIT = 5,
  parameter int unsigned CNT_BIT  = 12,
  parameter int unsigned INIT_CNT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_BIT-1:0]   in_ch,
  input  op_t                 in_op,
  input  logic [STEP_BIT-1:0] in_k,
  input  logic                in_sat,
  input  logic [CNT_BIT-1:0]  modulus,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_BIT-1:0]   out_ch,
  output logic [CNT_BIT-1:0]  out_cnt,
  output logic                out_flag
);

  typedef struct packed {
    logic [CH_BIT-1:0]  ch;
    logic [CNT_BIT-1:0] cnt;
    logic               flag;
  } result_t;

  logic [CNT_BIT-1:0] r_cnt [CHANNELS];
  result_t            r_out;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_ch_ok;
  logic [CNT_BIT-1:0] w_cur;
  logic [CNT_BIT-1:0] w_nxt;
  logic               w_flag;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_ch_ok  = 32'(in_ch) < CHANNELS;
  assign w_cur    = w_ch_ok ? r_cnt[in_ch] : '0;

  accum_alu #(
    .STEP_BIT(STEP_BIT),
    .CNT_BIT (CNT_BIT),
    .INIT_CNT(INIT_CNT)
  ) u_alu (
    .i_cnt    (w_cur),
    .i_k      (in_k),
    .i_op     (in_op),
    .i_sat    (in_sat),
    .i_modulus(modulus),
    .o_cnt    (w_nxt),
    .o_flag   (w_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_cnt[i] <= CNT_BIT'(INIT_CNT);
      end
    end else if (w_accept && w_ch_ok) begin
      r_cnt[in_ch] <= w_nxt;
    end
  end

  // Out-of-range channels still produce a beat, carrying zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out.ch    <= in_ch;
      r_out.cnt   <= w_ch_ok ? w_nxt : '0;
      r_out.flag  <= w_ch_ok ? w_flag : 1'b0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out.ch;
  assign out_cnt   = r_out.cnt;
  assign out_flag  = r_out.flag;

endmodule

// File: tb/tb_accum_mc.sv
// Directed self-checking bench for accum_mc with default parameters.
module tb_accum_mc;
  import accum_pkg::*;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned CH_BIT   = 2;
  localparam int unsigned STEP_BIT = 5;
  localparam int unsigned CNT_BIT  = 12;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [CH_BIT-1:0]   in_ch = '0;
  op_t                 in_op = OP_ADD;
  logic [STEP_BIT-1:0] in_k = '0;
  logic                in_sat = 1'b0;
  logic [CNT_BIT-1:0]  modulus = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [CH_BIT-1:0]   out_ch;
  logic [CNT_BIT-1:0]  out_cnt;
  logic                out_flag;

  int errors = 0;
  int checks = 0;

  logic              mon_en = 1'b0;
  logic [CNT_BIT:0]  beats[$];

  accum_mc #(
    .CHANNELS(CHANNELS),
    .CH_BIT  (CH_BIT),
    .STEP_BIT(STEP_BIT),
    .CNT_BIT (CNT_BIT),
    .INIT_CNT(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .in_op    (in_op),
    .in_k     (in_k),
    .in_sat   (in_sat),
    .modulus  (modulus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_cnt  (out_cnt),
    .out_flag (out_flag)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the negedge sees the handshake of the next edge.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) beats.push_back({out_flag, out_cnt});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [CH_BIT-1:0] ch, input op_t op, input int k, input logic sat);
    in_valid = 1'b1;
    in_ch    = ch;
    in_op    = op;
    in_k     = STEP_BIT'(k);
    in_sat   = sat;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_cnt !== '0 || out_flag !== 1'b0 || out_ch !== '0) begin
      errors++;
      $display("FAIL reset_out: v=%b ch=%0d cnt=%0d f=%b want 0/0/0/0",
               out_valid, out_ch, out_cnt, out_flag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    modulus = '0;
    for (int c = 0; c < 4; c++) begin
      drive(CH_BIT'(c), OP_ADD, 0, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== CH_BIT'(c) || out_cnt !== 12'd1 || out_flag !== 1'b0) begin
        errors++;
        $display("FAIL init_ch%0d: v=%b ch=%0d cnt=%0d f=%b want 1/%0d/1/0",
                 c, out_valid, out_ch, out_cnt, out_flag, c);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    modulus = 12'd20;
    drive(2'd0, OP_ADD, 19, 1'b0);
    tick();
    checks++;
    if (out_cnt !== 12'd0 || out_flag !== 1'b1) begin
      errors++;
      $display("FAIL wrap_k19: cnt=%0d f=%b want 0/1", out_cnt, out_flag);
    end
    drive(2'd0, OP_ADD, 5, 1'b0);
    tick();
    checks++;
    if (out_cnt !== 12'd5 || out_flag !== 1'b0) begin
      errors++;
      $display("FAIL wrap_k5: cnt=%0d f=%b want 5/0", out_cnt, out_flag);
    end
    drive(2'd1, OP_ADD, 0, 1'b0);
    tick();
    checks++;
    if (out_cnt !== 12'd1 || out_flag !== 1'b0 || out_ch !== 2'd1) begin
      errors++;
      $display("FAIL wrap_ch1_hold: ch=%0d cnt=%0d f=%b want 1/1/0", out_ch, out_cnt, out_flag);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturate();
    modulus = 12'd20;
    drive(2'd2, OP_ADD, 18, 1'b1);
    tick();
    checks++;
    if (out_cnt !== 12'd19 || out_flag !== 1'b0) begin
      errors++;
      $display("FAIL sat_k18: cnt=%0d f=%b want 19/0", out_cnt, out_flag);
    end
    drive(2'd2, OP_ADD, 3, 1'b1);
    tick();
    checks++;
    if (out_cnt !== 12'd19 || out_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_clip: cnt=%0d f=%b want 19/1", out_cnt, out_flag);
    end
    drive(2'd2, OP_CLEAR, 7, 1'b1);
    tick();
    checks++;
    if (out_cnt !== 12'd1 || out_flag !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: cnt=%0d f=%b want 1/0", out_cnt, out_flag);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mod_zero();
    modulus = '0;
    // 1 + 132*31 + 1 = 4094
    for (int i = 0; i < 132; i++) begin
      drive(2'd3, OP_ADD, 31, 1'b0);
      tick();
    end
    drive(2'd3, OP_ADD, 1, 1'b0);
    tick();
    checks++;
    if (out_cnt !== 12'd4094 || out_flag !== 1'b0) begin
      errors++;
      $display("FAIL mod0_ramp: cnt=%0d f=%b want 4094/0", out_cnt, out_flag);
    end
    drive(2'd3, OP_ADD, 3, 1'b0);
    tick();
    checks++;
    if (out_cnt !== 12'd1 || out_flag !== 1'b1) begin
      errors++;
      $display("FAIL mod0_wrap: cnt=%0d f=%b want 1/1", out_cnt, out_flag);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_lowered_modulus();
    // ch0 holds 5, ch2 holds 1; k=0 must still apply the limit.
    modulus = 12'd3;
    drive(2'd0, OP_ADD, 0, 1'b0);
    tick();
    checks++;
    if (out_cnt !== 12'd2 || out_flag !== 1'b1) begin
      errors++;
      $display("FAIL lowm_wrap: cnt=%0d f=%b want 2/1", out_cnt, out_flag);
    end
    modulus = 12'd1;
    drive(2'd2, OP_ADD, 0, 1'b1);
    tick();
    checks++;
    if (out_cnt !== 12'd0 || out_flag !== 1'b1) begin
      errors++;
      $display("FAIL lowm_sat: cnt=%0d f=%b want 0/1", out_cnt, out_flag);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    modulus = 12'd20;
    drive(2'd1, OP_ADD, 5, 1'b0);
    tick();
    checks++;
    if (out_cnt !== 12'd6) begin
      errors++;
      $display("FAIL b2b_first: cnt=%0d want 6", out_cnt);
    end
    drive(2'd1, OP_ADD, 5, 1'b0);
    tick();
    checks++;
    if (out_cnt !== 12'd11 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: cnt=%0d v=%b want 11/1", out_cnt, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [CNT_BIT:0] exp_beats [5];
    exp_beats[0] = {1'b0, 12'd4};
    exp_beats[1] = {1'b0, 12'd8};
    exp_beats[2] = {1'b0, 12'd13};
    exp_beats[3] = {1'b0, 12'd19};
    exp_beats[4] = {1'b1, 12'd6};
    modulus = 12'd20;
    drive(2'd0, OP_CLEAR, 0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    beats.delete();
    mon_en = 1'b1;
    drive(2'd0, OP_ADD, 3, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(2'd0, OP_ADD, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_cnt !== 12'd4 || out_ch !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold%0d: rdy=%b v=%b cnt=%0d want 0/1/4", i, in_ready, out_valid, out_cnt);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    drive(2'd0, OP_ADD, 5, 1'b0);
    tick();
    drive(2'd0, OP_ADD, 6, 1'b0);
    tick();
    drive(2'd0, OP_ADD, 7, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    mon_en = 1'b0;
    checks++;
    if (beats.size() != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d beats want 5", beats.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (beats[i] !== exp_beats[i]) begin
          errors++;
          $display("FAIL bp_beat%0d: got f=%b cnt=%0d want f=%b cnt=%0d", i, beats[i][CNT_BIT],
                   beats[i][CNT_BIT-1:0], exp_beats[i][CNT_BIT], exp_beats[i][CNT_BIT-1:0]);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: v=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    modulus = 12'd20;
    drive(2'd0, OP_ADD, 1, 1'b0);
    tick();
    // Reset mid-cycle, well before the next clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_cnt !== '0 || out_flag !== 1'b0 || out_ch !== '0) begin
      errors++;
      $display("FAIL async_rst: v=%b ch=%0d cnt=%0d f=%b want all 0",
               out_valid, out_ch, out_cnt, out_flag);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(2'd0, OP_ADD, 2, 1'b0);
    tick();
    checks++;
    if (out_cnt !== 12'd3 || out_flag !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_add: cnt=%0d f=%b v=%b want 3/0/1", out_cnt, out_flag, out_valid);
    end
    drive(2'd1, OP_ADD, 0, 1'b0);
    tick();
    checks++;
    if (out_cnt !== 12'd1) begin
      errors++;
      $display("FAIL post_rst_ch1: cnt=%0d want 1", out_cnt);
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_mod_zero();
    test_lowered_modulus();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
